// File: rtl/axi_fifo_pkt.sv
// AXI-Stream FIFO with two-stage registered output, occupancy/threshold flags and
// optional store-and-forward on tlast (PACKET_MODE=1).
module axi_fifo_pkt #(
  parameter int DATA_WIDTH          = 32,
  parameter int TUSER_WIDTH         = 8,
  parameter int ADDR_WIDTH          = 8,
  parameter int ALMOST_FULL_THRESH  = 16,
  parameter int ALMOST_EMPTY_THRESH = 4,
  parameter int PACKET_MODE         = 0
) (
  input  logic                     clk,
  input  logic                     sync_reset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [ADDR_WIDTH+1:0]    data_cnt,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ADDR_WIDTH:0]      pkt_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int WORD_W = DATA_WIDTH + TUSER_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   PTR_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   PKT_MAX = {(ADDR_WIDTH + 1){1'b1}};
  localparam logic [ADDR_WIDTH+1:0] AF_TH   = (ADDR_WIDTH + 2)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH+1:0] AE_TH   = (ADDR_WIDTH + 2)'(ALMOST_EMPTY_THRESH);

  logic [WORD_W-1:0]     mem_r [DEPTH];
  logic [WORD_W-1:0]     ram_rd_s;
  logic [ADDR_WIDTH:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [ADDR_WIDTH:0]   pkt_cnt_r, pkt_cnt_nxt_s;
  logic [ADDR_WIDTH+1:0] data_cnt_r, occ_nxt_s;
  logic [WORD_W-1:0]     s1_data_r, s2_data_r;
  logic                  s1_valid_r, s2_valid_r, s1_valid_nxt_s, s2_valid_nxt_s;
  logic                  full_s, empty_s, readable_s, wr_en_s, rd_en_s, s2_adv_s;
  logic                  pkt_inc_s, pkt_dec_s, almost_full_r, almost_empty_r;

  assign full_s   = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                    (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign ram_rd_s = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
  assign wr_en_s  = s_axis_tvalid & ~full_s;
  assign s2_adv_s = ~s2_valid_r | m_axis_tready;
  assign rd_en_s  = readable_s & (~s1_valid_r | ~s2_valid_r | m_axis_tready);
  assign pkt_inc_s = wr_en_s & s_axis_tlast;
  assign pkt_dec_s = rd_en_s & ram_rd_s[WORD_W-1];

  // RAM readability; in packet mode the full term lets oversize packets stream out
  always_comb begin
    readable_s = 1'b0;
    if (PACKET_MODE == 0) begin
      readable_s = ~empty_s;
    end else begin
      readable_s = ~empty_s & ((pkt_cnt_r != '0) | full_s);
    end
  end

  // Next-state values for pointers, stage valids, packet count and occupancy
  always_comb begin
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    s1_valid_nxt_s = s1_valid_r;
    s2_valid_nxt_s = s2_valid_r;
    pkt_cnt_nxt_s  = pkt_cnt_r;
    if (wr_en_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_en_s) begin
      rd_ptr_nxt_s   = rd_ptr_r + PTR_ONE;
      s1_valid_nxt_s = 1'b1;
    end else if (s2_adv_s) begin
      s1_valid_nxt_s = 1'b0;
    end else begin
      s1_valid_nxt_s = s1_valid_r;
    end
    if (s2_adv_s) begin
      s2_valid_nxt_s = s1_valid_r;
    end else begin
      s2_valid_nxt_s = s2_valid_r;
    end
    case ({pkt_inc_s, pkt_dec_s})
      2'b10: begin
        if (pkt_cnt_r != PKT_MAX) pkt_cnt_nxt_s = pkt_cnt_r + PTR_ONE;
        else pkt_cnt_nxt_s = pkt_cnt_r;
      end
      2'b01: begin
        if (pkt_cnt_r != '0) pkt_cnt_nxt_s = pkt_cnt_r - PTR_ONE;
        else pkt_cnt_nxt_s = pkt_cnt_r;
      end
      default: pkt_cnt_nxt_s = pkt_cnt_r;
    endcase
    occ_nxt_s = {1'b0, wr_ptr_nxt_s - rd_ptr_nxt_s} +
                {{(ADDR_WIDTH + 1){1'b0}}, s1_valid_nxt_s} +
                {{(ADDR_WIDTH + 1){1'b0}}, s2_valid_nxt_s};
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
  end

  // State, output pipeline and registered flags
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      s1_valid_r     <= 1'b0;
      s2_valid_r     <= 1'b0;
      s1_data_r      <= '0;
      s2_data_r      <= '0;
      pkt_cnt_r      <= '0;
      data_cnt_r     <= '0;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      wr_ptr_r       <= wr_ptr_nxt_s;
      rd_ptr_r       <= rd_ptr_nxt_s;
      s1_valid_r     <= s1_valid_nxt_s;
      s2_valid_r     <= s2_valid_nxt_s;
      pkt_cnt_r      <= pkt_cnt_nxt_s;
      data_cnt_r     <= occ_nxt_s;
      almost_full_r  <= (occ_nxt_s >= AF_TH);
      almost_empty_r <= (occ_nxt_s <= AE_TH);
      if (rd_en_s) s1_data_r <= ram_rd_s;
      if (s2_adv_s) s2_data_r <= s1_data_r;
    end
  end

  assign s_axis_tready = ~full_s;
  assign m_axis_tvalid = s2_valid_r;
  assign m_axis_tdata  = s2_data_r[DATA_WIDTH-1:0];
  assign m_axis_tuser  = s2_data_r[DATA_WIDTH +: TUSER_WIDTH];
  assign m_axis_tlast  = s2_data_r[WORD_W-1];
  assign data_cnt      = data_cnt_r;
  assign almost_full   = almost_full_r;
  assign almost_empty  = almost_empty_r;
  assign pkt_cnt       = pkt_cnt_r;

endmodule
